sipo_deframer: RTL
==================

Name: sipo_deframer

Overview:
- Serial receiver placed directly downstream of the 4-bit parallel-in/serial-out shifter.
- Collects framed serial bits into WIDTH-bit words and presents each word on a single-entry output register with a valid/ready handshake.
- Reports sticky overrun and framing errors to the control logic.

Parameters:
- WIDTH, 4: bits per word; legal values are 2 and above.
- MSB_FIRST, 1: 1 means the first received bit lands in word_out[WIDTH-1]; 0 means it lands in word_out[0].

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- serial_in  input  1  serial data bit from the upstream shifter.
- bit_valid  input  1  serial_in carries a valid bit this cycle.
- frame_start  input  1  qualified by bit_valid; marks the first bit of a word.
- word_ready  input  1  consumer accepts word_out this cycle.
- clr_err  input  1  clears overrun and frame_err.
- word_out  output  WIDTH  assembled word (holding register).
- word_valid  output  1  word_out holds an unconsumed word.
- busy  output  1  a frame is partially received (state is SHIFT).
- overrun  output  1  sticky: a completed word was dropped.
- frame_err  output  1  sticky: a frame was restarted before it completed.

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- Reset: state=IDLE, shift register=0, bit counter=0, word_out=0, word_valid=0, busy=0, overrun=0, frame_err=0. Reset mid-frame discards the partial word and any held word.
- FSM states: IDLE and SHIFT. busy is 1 exactly when the state is SHIFT.
- IDLE:
  - bit_valid=1 and frame_start=1: capture the first bit, counter=1, go to SHIFT.
  - bit_valid=1 and frame_start=0: bit ignored, no flag.
- SHIFT:
  - bit_valid=0: hold all state (stall). Gaps of any length are legal.
  - bit_valid=1 and frame_start=0: shift the bit in, counter += 1.
  - bit_valid=1 and frame_start=1: set frame_err, discard the partial word, restart with this bit as bit 0 (counter=1, stay in SHIFT).
- Shift order:
  - MSB_FIRST=1: sr <= {sr[WIDTH-2:0], serial_in}.
  - MSB_FIRST=0: sr <= {serial_in, sr[WIDTH-1:1]}.
- Completion: a bit accepted while counter==WIDTH-1 completes the word.
  - On that same edge, the assembled word (including this bit) is offered to the output register.
  - counter returns to 0 and state returns to IDLE.
  - Latency: word_valid=1 in the cycle after the last bit is sampled.
  - Back-to-back frames: frame_start may arrive on the cycle immediately after the last bit.
- Output handshake:
  - A transfer occurs on an edge where word_valid and word_ready are both 1.
  - Transfer, no completion: word_valid goes to 0; word_out holds its value.
  - Completion, with word_valid=0 or a transfer on the same edge: load word_out; word_valid=1.
  - Completion, with word_valid=1 and word_ready=0: new word dropped, word_out unchanged, overrun set.
- Error flags: overrun and frame_err clear only on clr_err or rst. If clr_err coincides with a new error event, set wins.
- word_out is never modified while word_valid=1 and no transfer occurs.

Decomposition:
- Shared header/package holds:
  - state encodings ST_IDLE=1'b0, ST_SHIFT=1'b1;
  - counter-width constant CNT_W = clog2(WIDTH).
- Single top module. One natural sub-module, sipo_shift_reg: WIDTH/MSB_FIRST shift register with enable and clear. Counter, FSM and handshake stay in the top module.

Test Plan:
- WIDTH=4, MSB_FIRST=1, word_ready=1; bits 0,1,1,1 on consecutive cycles, frame_start on the first. Required: word_out=4'b0111 with word_valid=1 for exactly one cycle, starting the cycle after the 4th bit; busy high for 3 cycles.
- Back-to-back frames 0111 then 0101, second frame_start on the cycle after the first frame's last bit. Required: two single-cycle valid pulses, 4 cycles apart; words 4'b0111 then 4'b0101; no flags.
- Stall: frame 1,0,1,0 with bit_valid=0 for 3 cycles between bits 2 and 3. Required: word_out=4'b1010; busy stays high through the gap; no frame_err.
- Overrun: word_ready=0, send 0111 then 0011. Required: word_out stays 4'b0111, overrun=1. Then clr_err pulse plus word_ready=1. Required: overrun=0, word_valid drops next cycle.
- Restart: send 1,1 then frame_start with bits 0,0,0,1. Required: frame_err=1, word_out=4'b0001. Repeat with MSB_FIRST=0 and bits 1,0,0,0. Required: word_out=4'b0001.
- Reset mid-frame: assert rst asynchronously (mid-cycle) after 2 bits, with a held word present. Required: all outputs 0 immediately; the next full frame 1,1,0,0 yields 4'b1100.

Source files
------------

// File: rtl/sipo_deframer_pkg.sv
// Shared constants for the serial deframer.
//   ST_IDLE / ST_SHIFT : FSM state encodings (1 bit, legacy-compatible constants)
//   cnt_width()        : width of the per-frame bit counter for a given word width
package sipo_deframer_pkg;

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_SHIFT = 1'b1;

   function automatic int cnt_width(input int width);
      return $clog2(width);
   endfunction

endpackage

// File: rtl/sipo_shift_reg.sv
// WIDTH-bit shift register for the deframer.
//   clk, rst   : clock, asynchronous active-high reset
//   en         : shift din in on this edge
//   clr        : shift into an all-zero register (used when a frame starts)
//   din        : serial bit
//   next_data  : value the register takes if en is asserted this cycle
// MSB_FIRST=1 shifts toward the MSB so the first bit ends in [WIDTH-1];
// MSB_FIRST=0 shifts toward the LSB so the first bit ends in [0].
module sipo_shift_reg #(
   parameter int WIDTH     = 4,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             clr,
   input  logic             din,
   output logic [WIDTH-1:0] next_data
);

   logic [WIDTH-1:0] data;
   logic [WIDTH-1:0] base;

   assign base = clr ? '0 : data;

   generate
      if (MSB_FIRST) begin : g_msb
         assign next_data = {base[WIDTH-2:0], din};
      end else begin : g_lsb
         assign next_data = {din, base[WIDTH-1:1]};
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data <= '0;
      end else if (en) begin
         data <= next_data;
      end
   end

endmodule

// File: rtl/sipo_deframer.sv
// Serial-to-parallel deframer with a single-entry valid/ready output register.
//   clk, rst     : clock, asynchronous active-high reset
//   serial_in    : serial data bit
//   bit_valid    : serial_in is valid this cycle
//   frame_start  : (with bit_valid) first bit of a word
//   word_ready   : consumer accepts word_out this cycle
//   clr_err      : clears the sticky error flags
//   word_out     : assembled word holding register
//   word_valid   : word_out holds an unconsumed word
//   busy         : a frame is partially received
//   overrun      : sticky, a completed word was dropped
//   frame_err    : sticky, a frame restarted before completing
//
// state    | meaning
// ST_IDLE  | waiting for a frame_start bit; stray bits ignored
// ST_SHIFT | collecting bits 1..WIDTH-1 of a frame
module sipo_deframer
   import sipo_deframer_pkg::*;
#(
   parameter int WIDTH     = 4,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             serial_in,
   input  logic             bit_valid,
   input  logic             frame_start,
   input  logic             word_ready,
   input  logic             clr_err,
   output logic [WIDTH-1:0] word_out,
   output logic             word_valid,
   output logic             busy,
   output logic             overrun,
   output logic             frame_err
);

   localparam int CNT_W = cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   logic [0:0]       state;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] sr_next;
   logic             start;
   logic             take_bit;
   logic             complete;
   logic             xfer;
   logic             restart_err;
   logic             drop;

   // A frame_start bit is always accepted; in SHIFT it also aborts the
   // partial word. Since WIDTH >= 2 the first bit can never complete a word.
   assign start       = bit_valid & frame_start;
   assign take_bit    = bit_valid & ~frame_start & (state == ST_SHIFT);
   assign complete    = take_bit & (cnt == CNT_LAST);
   assign restart_err = start & (state == ST_SHIFT);
   assign xfer        = word_valid & word_ready;
   assign drop        = complete & word_valid & ~word_ready;
   assign busy        = (state == ST_SHIFT);

   sipo_shift_reg #(
      .WIDTH     (WIDTH),
      .MSB_FIRST (MSB_FIRST)
   ) u_shift (
      .clk       (clk),
      .rst       (rst),
      .en        (start | take_bit),
      .clr       (start),
      .din       (serial_in),
      .next_data (sr_next)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else if (start) begin
         state <= ST_SHIFT;
         cnt   <= CNT_W'(1);
      end else if (complete) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else if (take_bit) begin
         cnt   <= cnt + CNT_W'(1);
      end
   end

   // Holding register: the completed word (which includes the bit sampled
   // on this edge, hence sr_next) loads only when the slot is free or
   // being emptied on the same edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         word_out   <= '0;
         word_valid <= 1'b0;
      end else if (complete && (!word_valid || xfer)) begin
         word_out   <= sr_next;
         word_valid <= 1'b1;
      end else if (xfer) begin
         word_valid <= 1'b0;
      end
   end

   // New error events take priority over clr_err.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overrun   <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         overrun   <= drop | (overrun & ~clr_err);
         frame_err <= restart_err | (frame_err & ~clr_err);
      end
   end

endmodule
